// File: rtl/tt_um_loopback_checker.sv
// Loopback self-test: drives an LFSR pattern on uo_out, then on the bidir pins,
// checks what comes back each cycle and reports {pass, error count} on uo_out.
module tt_um_loopback_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE,
        RUN_O,
        RUN_IO,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] step;
    logic [6:0] err;

    logic [7:0] lfsr_next;
    logic       mismatch;
    logic [6:0] err_next;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Compare against the registered outputs presented this cycle; on odd
    // RUN_IO steps uio_out is already 00, so one compare covers both phases.
    always_comb begin
        mismatch = 1'b0;
        case (state)
            RUN_O:   mismatch = (ui_in != uo_out);
            RUN_IO:  mismatch = (uio_in != uio_out);
            default: mismatch = 1'b0;
        endcase
    end

    assign err_next = (mismatch && (err != 7'h7F)) ? err + 7'd1 : err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= 8'h01;
            step    <= 8'd0;
            err     <= 7'd0;
            uo_out  <= 8'h00;
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
        end else if (!ena) begin
            state   <= IDLE;
            lfsr    <= 8'h01;
            step    <= 8'd0;
            err     <= 7'd0;
            uo_out  <= 8'h00;
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    state   <= RUN_O;
                    lfsr    <= 8'h01;
                    step    <= 8'd0;
                    err     <= 7'd0;
                    uo_out  <= 8'h01;
                    uio_out <= 8'h00;
                    uio_oe  <= 8'h00;
                end
                RUN_O: begin
                    err  <= err_next;
                    lfsr <= lfsr_next;
                    if (step == 8'd254) begin
                        // Step 0 of RUN_IO is even, so the bidir pins start out driven.
                        state   <= RUN_IO;
                        step    <= 8'd0;
                        uo_out  <= 8'h00;
                        uio_out <= lfsr_next;
                        uio_oe  <= 8'hFF;
                    end else begin
                        step   <= step + 8'd1;
                        uo_out <= lfsr_next;
                    end
                end
                RUN_IO: begin
                    err  <= err_next;
                    lfsr <= lfsr_next;
                    step <= step + 8'd1;
                    if (step == 8'd255) begin
                        state   <= DONE;
                        uo_out  <= {(err_next == 7'd0), err_next};
                        uio_out <= 8'h00;
                        uio_oe  <= 8'h00;
                    end else if (step[0]) begin
                        uio_out <= lfsr_next;
                        uio_oe  <= 8'hFF;
                    end else begin
                        uio_out <= 8'h00;
                        uio_oe  <= 8'h00;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_loopback_checker.sv
// Bench for tt_um_loopback_checker: a loopback fixture with optional planted faults,
// an independent reference model feeding a scoreboard queue of expected outputs.
module tb_tt_um_loopback_checker;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uout;
        logic [7:0] uoe;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] res_q[$];
    int         total;
    int         bad;
    int         mode;
    int         cyc;

    tt_um_loopback_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: raises ena, fills the scoreboard from the reference
    // model for fault mode m, and lets the IDLE-exit edge happen.
    task automatic apply_stimulus(input int m);
        logic [7:0] l;
        logic [7:0] drv;
        int         e;
        exp_t       x;
        mode = m;
        cyc  = 0;
        ena  = 1'b1;
        l    = 8'h01;
        e    = 0;
        for (int k = 0; k < 255; k++) begin
            x.uo = l; x.uout = 8'h00; x.uoe = 8'h00;
            exp_q.push_back(x);
            drv = l;
            if (m == 1) drv[0] = 1'b0;
            if (m == 2 && k == 9) drv[3] = ~drv[3];
            if (drv != l) e++;
            l = lfsr_adv(l);
        end
        for (int s = 0; s < 256; s++) begin
            if ((s % 2) == 0) begin
                x.uo = 8'h00; x.uout = l; x.uoe = 8'hFF;
                drv = (m == 3) ? 8'h00 : l;
                if (drv != l) e++;
            end else begin
                x.uo = 8'h00; x.uout = 8'h00; x.uoe = 8'h00;
            end
            exp_q.push_back(x);
            l = lfsr_adv(l);
        end
        res_q.push_back({(e == 0), (e > 127) ? 7'h7F : 7'(e)});
        @(posedge clk);
    endtask

    task automatic step_cycles(input int n);
        exp_t       x;
        logic [7:0] drv;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_output("scoreboard_empty", 8'h01, 8'h00);
            end else begin
                x = exp_q.pop_front();
                check_output("uo_out", uo_out, x.uo);
                check_output("uio_out", uio_out, x.uout);
                check_output("uio_oe", uio_oe, x.uoe);
                if (mode == 0 && cyc == 4) check_output("lfsr_fifth", uo_out, 8'h11);
            end
            drv = uo_out;
            if (mode == 1) drv[0] = 1'b0;
            if (mode == 2 && cyc == 9) drv[3] = ~drv[3];
            ui_in  = drv;
            uio_in = (mode == 3) ? 8'h00 : (uio_out & uio_oe);
            cyc++;
        end
    endtask

    task automatic finish_run();
        logic [7:0] r;
        @(negedge clk);
        r = (res_q.size() != 0) ? res_q.pop_front() : 8'hXX;
        check_output("done_result", uo_out, r);
        check_output("done_uio_oe", uio_oe, 8'h00);
        check_output("done_uio_out", uio_out, 8'h00);
        @(negedge clk);
        check_output("done_hold", uo_out, r);
    endtask

    task automatic go_idle();
        ena = 1'b0;
        @(negedge clk);
        check_output("idle_uo_out", uo_out, 8'h00);
        check_output("idle_uio_out", uio_out, 8'h00);
        check_output("idle_uio_oe", uio_oe, 8'h00);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mode   = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #3;
        check_output("reset_uo_out", uo_out, 8'h00);
        check_output("reset_uio_out", uio_out, 8'h00);
        check_output("reset_uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_wait_uo_out", uo_out, 8'h00);

        $display("[TB] ideal loopback run");
        apply_stimulus(0);
        step_cycles(511);
        finish_run();
        go_idle();

        $display("[TB] ui_in[0] stuck low run");
        apply_stimulus(1);
        step_cycles(511);
        finish_run();
        go_idle();

        $display("[TB] single bit-3 flip run");
        apply_stimulus(2);
        step_cycles(511);
        finish_run();
        go_idle();

        $display("[TB] uio_in forced low run");
        apply_stimulus(3);
        step_cycles(511);
        finish_run();
        go_idle();

        $display("[TB] ena abort on 100th RUN_O cycle");
        apply_stimulus(0);
        step_cycles(100);
        ena = 1'b0;
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        check_output("abort_uo_out", uo_out, 8'h00);
        check_output("abort_uio_out", uio_out, 8'h00);
        check_output("abort_uio_oe", uio_oe, 8'h00);
        apply_stimulus(0);
        step_cycles(511);
        finish_run();
        go_idle();

        $display("[TB] async reset mid RUN_IO");
        apply_stimulus(0);
        step_cycles(301);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_uo_out", uo_out, 8'h00);
        check_output("async_rst_uio_out", uio_out, 8'h00);
        check_output("async_rst_uio_oe", uio_oe, 8'h00);
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0);
        step_cycles(511);
        finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_loopback_checker.md
TT_UM_LOOPBACK_CHECKER -- requirements
Module: tt_um_loopback_checker

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port ena, input, 1, run gate; high starts or continues a test, low aborts it.
REQ-004 SHALL have port ui_in, input, 8, dedicated inputs; carry uo_out back in a loopback fixture.
REQ-005 SHALL have port uo_out, output, 8, dedicated outputs; carry the test pattern or the result.
REQ-006 SHALL have port uio_in, input, 8, bidirectional pin inputs; carry uio_out & uio_oe back in a loopback fixture.
REQ-007 SHALL have port uio_out, output, 8, bidirectional pin output values.
REQ-008 SHALL have port uio_oe, output, 8, bidirectional output enables; 1 = drive.
REQ-009 SHALL register all outputs, with no combinational path from any input to any output.

Function
REQ-010 SHALL implement FSM states IDLE, RUN_O, RUN_IO, DONE.
REQ-011 SHALL contain an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
- Next state = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Seed 8'h01; sequence starts 01, 02, 04, 08, 11.
REQ-012 SHALL contain an 8-bit step counter and a 7-bit error counter that saturates at 7'h7F.
REQ-013 IDLE SHALL drive uo_out=00, uio_out=00, uio_oe=00.
- With ena=1: next cycle enter RUN_O, lfsr=01, step=0, err=0.
REQ-014 RUN_O, each cycle:
- uo_out = lfsr; uio_oe = 00.
- Sample ui_in; if ui_in != uo_out, increment err.
- Advance lfsr; increment step.
- After step 254 (255 cycles): enter RUN_IO with step=0; lfsr continues without reseed.
REQ-015 RUN_IO, even step:
- uio_oe=FF, uio_out=lfsr.
- Error if uio_in != uio_out.
REQ-016 RUN_IO, odd step:
- uio_oe=00, uio_out=00.
- Error if uio_in != 00.
REQ-017 RUN_IO general rules:
- uo_out=00.
- lfsr advances every cycle.
- After step 255 (256 cycles): enter DONE.
REQ-018 DONE SHALL drive uo_out = {pass, err[6:0]}, pass = (err==0); uio_oe=00, uio_out=00.
- Hold while ena=1.
REQ-019 Comparison SHALL use input values sampled in the same cycle the registered output is presented, i.e. zero-latency loopback.
- Total test length: 1 IDLE exit + 255 + 256 cycles.
REQ-020 ena=0 in any state SHALL, on the next edge:
- enter IDLE;
- clear lfsr to 01 and step and err to 0;
- drive all outputs to 00.
REQ-021 An error on the cycle err is already 7'h7F SHALL leave err at 7'h7F; a simultaneous state transition SHALL still occur.
REQ-022 Step counter wrap SHALL only occur at the RUN_IO->DONE transition; no other wrap-around SHALL occur.

Reset
REQ-023 rst_n low SHALL immediately, without a clock:
- set state IDLE, lfsr=01, step=0, err=0;
- set uo_out=00, uio_out=00, uio_oe=00.
REQ-024 Release of rst_n with ena=1 SHALL start a test on the first subsequent clock edge.
REQ-025 Reset asserted mid-test SHALL discard all progress; no partial result SHALL be reported.

Verification
REQ-026 Ideal loopback (ui_in=uo_out; uio_in=uio_out&uio_oe), ena=1 -> DONE after 512 edges, uo_out=8'h80.
REQ-027 ui_in[0] stuck at 0 -> 128 mismatches saturate; DONE uo_out=8'h7F.
REQ-028 Ideal loopback except ui_in bit 3 flipped on the 10th RUN_O cycle only -> DONE uo_out=8'h01.
REQ-029 uio_in forced 00 -> errors only on even RUN_IO steps with lfsr!=0 (128) -> DONE uo_out=8'h7F.
- During odd steps, check uio_oe=00.
REQ-030 ena dropped on the 100th RUN_O cycle:
- Next edge: outputs 00, state IDLE.
- ena re-raised with ideal loopback -> fresh run ends with uo_out=8'h80.
REQ-031 rst_n pulsed low mid RUN_IO between clock edges:
- Outputs 00 before next edge.
- After release, full clean run -> 8'h80.
